// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer: serial back end turning LCD controller write requests into 4-wire SPI bytes and reset-pin updates.
//   clk, rst      : system clock, synchronous active-high reset
//   en_i[1:0]     : request, bit0 = SPI byte write, bit1 = reset-pin write
//   data_i[8:0]   : bit8 = D/C, bits7:0 = byte (MSB first); bit0 = reset level for pin writes
//   done_o[1:0]   : one-cycle completion pulse, bit0 = byte written, bit1 = reset pin updated
//   busy_o        : high while a byte is in flight
//   lcd_cs_n_o, lcd_sclk_o, lcd_mosi_o, lcd_dc_o : SPI mode 0 pins
//   lcd_rst_o     : panel hardware reset, active low
module lcd_spi_writer #(
    parameter int CLK_DIV        = 2,
    parameter bit RST_LEVEL_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] en_i,
    input  logic [8:0] data_i,
    output logic [1:0] done_o,
    output logic       busy_o,
    output logic       lcd_cs_n_o,
    output logic       lcd_sclk_o,
    output logic       lcd_mosi_o,
    output logic       lcd_dc_o,
    output logic       lcd_rst_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;
    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);
    state_t state, state_nx;
    logic [7:0] ph;
    logic [2:0] bit_cnt;
    logic [6:0] sh;
    logic ph_end;
    assign ph_end = ph == PH_LAST;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = en_i[0] ? SHIFT : IDLE;
            SHIFT: state_nx = (ph_end && lcd_sclk_o && bit_cnt == 3'd0) ? HOLD : SHIFT;
            HOLD:  state_nx = ph_end ? DONE : HOLD;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ph         <= 8'd0;
            bit_cnt    <= 3'd0;
            sh         <= 7'd0;
            done_o     <= 2'b00;
            busy_o     <= 1'b0;
            lcd_cs_n_o <= 1'b1;
            lcd_sclk_o <= 1'b0;
            lcd_mosi_o <= 1'b0;
            lcd_dc_o   <= 1'b0;
            lcd_rst_o  <= RST_LEVEL_INIT;
        end else begin
            state  <= state_nx;
            done_o <= 2'b00;
            // phase counter runs only while a frame is active and restarts each half-period
            ph <= ((state == SHIFT || state == HOLD) && !ph_end) ? ph + 8'd1 : 8'd0;
            case (state)
                IDLE: begin
                    if (en_i[0]) begin
                        sh         <= data_i[6:0];
                        bit_cnt    <= 3'd7;
                        lcd_cs_n_o <= 1'b0;
                        lcd_dc_o   <= data_i[8];
                        lcd_mosi_o <= data_i[7];
                        busy_o     <= 1'b1;
                    end else if (en_i[1]) begin
                        lcd_rst_o <= data_i[0];
                        done_o    <= 2'b10;
                    end
                end
                SHIFT: begin
                    if (ph_end) begin
                        lcd_sclk_o <= !lcd_sclk_o;
                        // next bit is presented on the falling edge, except after the last bit
                        if (lcd_sclk_o && bit_cnt != 3'd0) begin
                            bit_cnt    <= bit_cnt - 3'd1;
                            sh         <= {sh[5:0], 1'b0};
                            lcd_mosi_o <= sh[6];
                        end
                    end
                end
                HOLD: begin
                    if (ph_end) begin
                        lcd_cs_n_o <= 1'b1;
                        done_o     <= 2'b01;
                        busy_o     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
